// File: rtl/lcd_write_arbiter_pkg.sv
// Shared drawing-block definitions: LCD coordinate/pixel widths and the
// pixel-write arbiter state encoding.
package lcd_write_arbiter_pkg;

  localparam int X_W      = 8;   // LCD x coordinate width
  localparam int Y_W      = 9;   // LCD y coordinate width
  localparam int RGB565_W = 16;  // RGB565 pixel width

  // IDLE must stay at encoding 0: it is the reset state.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } lcd_wr_state_e;

endpackage

// File: rtl/lcd_write_arbiter_if.sv
// Bundle of the requester-side and LCD-writer-side signals of the pixel-write
// arbiter.
//
// Handshake: a requester raises req[i] with its x/y/pixel fields valid and
// holds all of them until it sees ack[i] (one-cycle pulse, write done) or
// error (one-cycle pulse, write aborted). lcdPixelWrite is a one-cycle strobe
// whose lcdXAddr/lcdYAddr/lcdPixelData are valid in the same cycle; the
// arbiter only starts a new unlocked write while lcdPixelReady is high.
interface lcd_write_arbiter_if
  import lcd_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) ();

  logic [NUM_REQ-1:0]          req;
  logic [NUM_REQ-1:0]          lock;
  logic [NUM_REQ*X_W-1:0]      xAddr;
  logic [NUM_REQ*Y_W-1:0]      yAddr;
  logic [NUM_REQ*RGB565_W-1:0] pixelData;
  logic [NUM_REQ-1:0]          ack;
  logic                        error;
  logic [NUM_REQ-1:0]          grant;
  logic [X_W-1:0]              lcdXAddr;
  logic [Y_W-1:0]              lcdYAddr;
  logic [RGB565_W-1:0]         lcdPixelData;
  logic                        lcdPixelWrite;
  logic                        lcdPixelReady;

  // Requesters plus LCD writer: the side that surrounds the arbiter.
  modport master (
    output req, lock, xAddr, yAddr, pixelData, lcdPixelReady,
    input  ack, error, grant, lcdXAddr, lcdYAddr, lcdPixelData, lcdPixelWrite
  );

  // The arbiter itself.
  modport slave (
    input  req, lock, xAddr, yAddr, pixelData, lcdPixelReady,
    output ack, error, grant, lcdXAddr, lcdYAddr, lcdPixelData, lcdPixelWrite
  );

endinterface

// File: rtl/lcd_write_arbiter_rr_priority_select.sv
// Round-robin priority selector: searches req starting at rrPtr and wrapping,
// returning the first set bit as a one-hot winner.
module rr_priority_select #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] rrPtr,
  output logic [N-1:0]  winner,
  output logic          valid
);

  // Walk the ring from rrPtr and keep the first requester found.
  always_comb begin
    logic [PW-1:0] idx;
    idx    = '0;
    winner = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(rrPtr) + k) % N);
      if (req[idx] && (winner == '0)) begin
        winner[idx] = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/lcd_write_arbiter.sv
// Pixel-write arbiter: picks one of NUM_REQ requesters round robin, registers
// its coordinates/pixel, strobes the LCD writer, waits for completion (with a
// timeout) and acknowledges. A locked requester keeps the port between writes.
module lcd_write_arbiter
  import lcd_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          lock,
  input  logic [NUM_REQ*X_W-1:0]      xAddr,
  input  logic [NUM_REQ*Y_W-1:0]      yAddr,
  input  logic [NUM_REQ*RGB565_W-1:0] pixelData,
  output logic [NUM_REQ-1:0]          ack,
  output logic                        error,
  output logic [NUM_REQ-1:0]          grant,
  output logic [X_W-1:0]              lcdXAddr,
  output logic [Y_W-1:0]              lcdYAddr,
  output logic [RGB565_W-1:0]         lcdPixelData,
  output logic                        lcdPixelWrite,
  input  logic                        lcdPixelReady,
  output lcd_wr_state_e               dbg_state
);

  localparam int            PW     = $clog2(NUM_REQ);
  localparam int            CW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CYCLES);

  lcd_wr_state_e       state_q, state_d;
  logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]       gidx_q, gidx_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                error_q, error_d;
  logic                wr_q, wr_d;
  logic [X_W-1:0]      x_q, x_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic [RGB565_W-1:0] pix_q, pix_d;
  logic [CW-1:0]       wait_cnt_q, wait_cnt_d;

  logic [NUM_REQ-1:0]  sel_onehot;
  logic                sel_valid;
  logic [PW-1:0]       sel_idx;
  logic [PW-1:0]       ld_idx;
  logic [PW-1:0]       rr_next;
  logic [CW-1:0]       wait_cnt_inc;

  rr_priority_select #(.N(NUM_REQ), .PW(PW)) u_rr_priority_select (
    .req    (req),
    .rrPtr  (rr_ptr_q),
    .winner (sel_onehot),
    .valid  (sel_valid)
  );

  // One-hot winner to index, used to pick the winner's packed fields.
  always_comb begin
    sel_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (sel_onehot[k]) sel_idx = PW'(k);
    end
  end

  // A locked continuation reloads from the current owner; otherwise the winner.
  assign ld_idx       = (state_q == DONE) ? gidx_q : sel_idx;
  assign rr_next      = (gidx_q == PW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
  assign wait_cnt_inc = (wait_cnt_q == TO_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;

  // Next-state and registered-output computation for the write FSM.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gidx_d     = gidx_q;
    grant_d    = grant_q;
    ack_d      = '0;
    error_d    = 1'b0;
    wr_d       = 1'b0;
    x_d        = x_q;
    y_d        = y_q;
    pix_d      = pix_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (sel_valid && lcdPixelReady) begin
          gidx_d  = sel_idx;
          grant_d = sel_onehot;
          x_d     = xAddr[ld_idx*X_W +: X_W];
          y_d     = yAddr[ld_idx*Y_W +: Y_W];
          pix_d   = pixelData[ld_idx*RGB565_W +: RGB565_W];
          wr_d    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wait_cnt_d = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        // The writer's ready can still be stale in the first WAIT cycle.
        if ((wait_cnt_q != '0) && lcdPixelReady) begin
          ack_d      = grant_q;
          wait_cnt_d = '0;
          state_d    = DONE;
        end else if (wait_cnt_inc == TO_MAX) begin
          error_d    = 1'b1;
          grant_d    = '0;
          rr_ptr_d   = rr_next;
          wait_cnt_d = '0;
          state_d    = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_inc;
        end
      end
      DONE: begin
        if (lock[gidx_q] && req[gidx_q]) begin
          x_d     = xAddr[ld_idx*X_W +: X_W];
          y_d     = yAddr[ld_idx*Y_W +: Y_W];
          pix_d   = pixelData[ld_idx*RGB565_W +: RGB565_W];
          wr_d    = 1'b1;
          state_d = ISSUE;
        end else begin
          grant_d  = '0;
          rr_ptr_d = rr_next;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      gidx_q     <= '0;
      grant_q    <= '0;
      ack_q      <= '0;
      error_q    <= 1'b0;
      wr_q       <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      pix_q      <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gidx_q     <= gidx_d;
      grant_q    <= grant_d;
      ack_q      <= ack_d;
      error_q    <= error_d;
      wr_q       <= wr_d;
      x_q        <= x_d;
      y_q        <= y_d;
      pix_q      <= pix_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign ack           = ack_q;
  assign error         = error_q;
  assign grant         = grant_q;
  assign lcdXAddr      = x_q;
  assign lcdYAddr      = y_q;
  assign lcdPixelData  = pix_q;
  assign lcdPixelWrite = wr_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Bench for lcd_write_arbiter: directed scenarios drive requesters and a
// simple LCD-writer model; a monitor checks strobes, acks and errors against
// expected queues filled when each scenario is set up.
module tb_lcd_write_arbiter;
  import lcd_write_arbiter_pkg::*;

  localparam int NR = 4;
  localparam int TO = 8;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  int   cyc = 0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  lcd_write_arbiter_if #(.NUM_REQ(NR)) bus ();
  lcd_wr_state_e dbg_state;

  lcd_write_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
    .clock         (clock),
    .reset         (reset),
    .req           (bus.req),
    .lock          (bus.lock),
    .xAddr         (bus.xAddr),
    .yAddr         (bus.yAddr),
    .pixelData     (bus.pixelData),
    .ack           (bus.ack),
    .error         (bus.error),
    .grant         (bus.grant),
    .lcdXAddr      (bus.lcdXAddr),
    .lcdYAddr      (bus.lcdYAddr),
    .lcdPixelData  (bus.lcdPixelData),
    .lcdPixelWrite (bus.lcdPixelWrite),
    .lcdPixelReady (bus.lcdPixelReady),
    .dbg_state     (dbg_state)
  );

  // ---------------- scoreboard ----------------
  // Write entry: {requester[2:0], x[7:0], y[8:0], pixel[15:0]}
  logic [35:0]   exp_q[$];
  logic [NR-1:0] ack_exp_q[$];
  int            err_exp;
  int            checks;
  int            failures;
  int            strobe_cyc[$];
  int            ack_cyc[$];
  int            err_cyc[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input bit bad);
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL %s actual=event required=no_event", name);
    end
  endtask

  task automatic expect_wr(input int i, input logic [7:0] x, input logic [8:0] y,
                           input logic [15:0] d);
    exp_q.push_back({3'(i), x, y, d});
  endtask

  // Monitor: pops and compares whenever the DUT presents a strobe/ack/error.
  initial begin : monitor
    logic [35:0] e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (bus.lcdPixelWrite) begin
          strobe_cyc.push_back(cyc);
          flag("strobe_expected", exp_q.size() == 0);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("strobe_grant", bus.grant, 64'(4'b0001 << e[35:33]));
            chk("strobe_x", bus.lcdXAddr, e[32:25]);
            chk("strobe_y", bus.lcdYAddr, e[24:16]);
            chk("strobe_pixel", bus.lcdPixelData, e[15:0]);
          end
        end
        if (bus.ack != '0) begin
          ack_cyc.push_back(cyc);
          flag("ack_expected", ack_exp_q.size() == 0);
          if (ack_exp_q.size() != 0) chk("ack_onehot", bus.ack, ack_exp_q.pop_front());
        end
        if (bus.error) begin
          err_cyc.push_back(cyc);
          flag("error_expected", err_exp == 0);
          if (err_exp != 0) begin
            err_exp--;
            chk("error_grant_cleared", bus.grant, 0);
            chk("error_state_idle", dbg_state, IDLE);
          end
        end
      end
    end
  end

  // ---------------- driver (requesters + LCD writer model) ----------------
  logic [35:0] tab [NR][4];
  int          n_wr [NR];
  int          k_wr [NR];
  int          start_at [NR];
  int          req_cyc [NR];
  logic        started [NR];
  logic        lock_cfg [NR];
  int          rdy_dly;
  logic        stuck;
  int          w_cnt;

  task automatic present(input int i, input int k);
    bus.xAddr[i*X_W +: X_W]                 = tab[i][k][32:25];
    bus.yAddr[i*Y_W +: Y_W]                 = tab[i][k][24:16];
    bus.pixelData[i*RGB565_W +: RGB565_W]   = tab[i][k][15:0];
  endtask

  task automatic set_wr(input int i, input int k, input logic [7:0] x,
                        input logic [8:0] y, input logic [15:0] d);
    tab[i][k] = {3'(i), x, y, d};
    if (n_wr[i] < k + 1) n_wr[i] = k + 1;
    start_at[i] = cyc + 1;
  endtask

  task automatic clear_cfg();
    for (int i = 0; i < NR; i++) begin
      n_wr[i] = 0; k_wr[i] = 0; started[i] = 1'b0; lock_cfg[i] = 1'b0;
      start_at[i] = 0; req_cyc[i] = 0;
    end
    bus.req = '0; bus.lock = '0; bus.xAddr = '0; bus.yAddr = '0; bus.pixelData = '0;
    bus.lcdPixelReady = 1'b1;
    stuck = 1'b0; w_cnt = 0; rdy_dly = 1;
    strobe_cyc.delete(); ack_cyc.delete(); err_cyc.delete();
  endtask

  // One negedge worth of requester and LCD-writer behaviour.
  task automatic driver_step();
    for (int i = 0; i < NR; i++) begin
      if (!started[i] && n_wr[i] > 0 && cyc >= start_at[i]) begin
        started[i] = 1'b1; req_cyc[i] = cyc;
        present(i, 0);
        bus.req[i] = 1'b1; bus.lock[i] = lock_cfg[i];
      end else if (started[i] && bus.ack[i]) begin
        k_wr[i]++;
        if (k_wr[i] < n_wr[i]) present(i, k_wr[i]);
        else begin bus.req[i] = 1'b0; bus.lock[i] = 1'b0; end
      end
    end
    if (bus.error) begin
      for (int i = 0; i < NR; i++) n_wr[i] = k_wr[i];
      bus.req = '0; bus.lock = '0;
    end
    if (w_cnt > 0) begin
      w_cnt--;
      if (w_cnt == 0 && !stuck) bus.lcdPixelReady = 1'b1;
    end
    if (bus.lcdPixelWrite) begin
      bus.lcdPixelReady = 1'b0;
      w_cnt = rdy_dly;
    end
  endtask

  function automatic bit all_done();
    bit d;
    d = (exp_q.size() == 0) && (ack_exp_q.size() == 0) && (err_exp == 0);
    for (int i = 0; i < NR; i++)
      if (n_wr[i] > 0 && (!started[i] || k_wr[i] < n_wr[i])) d = 1'b0;
    return d;
  endfunction

  task automatic run(input string name, input int limit);
    int t;
    bit d;
    t = 0; d = 1'b0;
    while (!d && t < limit) begin
      @(negedge clock);
      driver_step();
      t++;
      d = all_done();
    end
    checks++;
    if (!d) begin
      failures++;
      $display("FAIL %s_complete actual=pending_after_%0d_cycles required=done", name, limit);
    end
    repeat (3) begin @(negedge clock); driver_step(); end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_cfg();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  function automatic int gap(input int a, input int b);
    return (strobe_cyc.size() > b) ? strobe_cyc[b] - strobe_cyc[a] : -1;
  endfunction

  // ---------------- scenarios ----------------
  initial begin
    int t;
    checks = 0; failures = 0; err_exp = 0;
    reset = 1'b1;
    clear_cfg();
    repeat (2) @(negedge clock);

    // Reset state
    chk("rst_state", dbg_state, IDLE);
    chk("rst_grant", bus.grant, 0);
    chk("rst_ack", bus.ack, 0);
    chk("rst_error", bus.error, 0);
    chk("rst_strobe", bus.lcdPixelWrite, 0);
    chk("rst_x", bus.lcdXAddr, 0);
    chk("rst_y", bus.lcdYAddr, 0);
    chk("rst_pixel", bus.lcdPixelData, 0);
    reset = 1'b0;
    @(negedge clock);

    // Scenario 1: single write, writer ready returns 3 cycles after strobe
    rdy_dly = 3;
    set_wr(0, 0, 8'd10, 9'd20, 16'hF800);
    expect_wr(0, 8'd10, 9'd20, 16'hF800);
    ack_exp_q.push_back(4'b0001);
    run("s1", 100);
    chk("s1_req_to_strobe", (strobe_cyc.size() > 0) ? strobe_cyc[0] - req_cyc[0] : -1, 1);
    chk("s1_req_to_ack", (ack_cyc.size() > 0) ? ack_cyc[0] - req_cyc[0] : -1, 5);

    // Scenario 2: all four request, unlocked -> 0,1,2,3,0
    do_reset();
    set_wr(0, 0, 8'h10, 9'h011, 16'h1111);
    set_wr(1, 0, 8'h21, 9'h022, 16'h2222);
    set_wr(2, 0, 8'h32, 9'h033, 16'h3333);
    set_wr(3, 0, 8'h43, 9'h044, 16'h4444);
    set_wr(0, 1, 8'h54, 9'h155, 16'h5555);
    expect_wr(0, 8'h10, 9'h011, 16'h1111);
    expect_wr(1, 8'h21, 9'h022, 16'h2222);
    expect_wr(2, 8'h32, 9'h033, 16'h3333);
    expect_wr(3, 8'h43, 9'h044, 16'h4444);
    expect_wr(0, 8'h54, 9'h155, 16'h5555);
    ack_exp_q.push_back(4'b0001); ack_exp_q.push_back(4'b0010);
    ack_exp_q.push_back(4'b0100); ack_exp_q.push_back(4'b1000);
    ack_exp_q.push_back(4'b0001);
    run("s2", 200);
    chk("s2_unlocked_spacing", gap(0, 1), 5);
    chk("s2_unlocked_spacing_wrap", gap(3, 4), 5);

    // Scenario 3: requester 1 locked for 3 writes, requester 0 arrives later
    do_reset();
    lock_cfg[1] = 1'b1;
    set_wr(1, 0, 8'hA1, 9'h1A1, 16'hA1A1);
    set_wr(1, 1, 8'hA2, 9'h1A2, 16'hA2A2);
    set_wr(1, 2, 8'hA3, 9'h1A3, 16'hA3A3);
    set_wr(0, 0, 8'hB0, 9'h0B0, 16'hB0B0);
    start_at[0] = cyc + 2;
    expect_wr(1, 8'hA1, 9'h1A1, 16'hA1A1);
    expect_wr(1, 8'hA2, 9'h1A2, 16'hA2A2);
    expect_wr(1, 8'hA3, 9'h1A3, 16'hA3A3);
    expect_wr(0, 8'hB0, 9'h0B0, 16'hB0B0);
    ack_exp_q.push_back(4'b0010); ack_exp_q.push_back(4'b0010);
    ack_exp_q.push_back(4'b0010); ack_exp_q.push_back(4'b0001);
    run("s3", 200);
    chk("s3_locked_spacing_1", gap(0, 1), 4);
    chk("s3_locked_spacing_2", gap(1, 2), 4);
    chk("s3_handover_spacing", gap(2, 3), 5);

    // Scenario 4: writer stuck -> timeout after 8 WAIT cycles, no ack
    do_reset();
    stuck = 1'b1;
    set_wr(2, 0, 8'h77, 9'h0EE, 16'h07E0);
    expect_wr(2, 8'h77, 9'h0EE, 16'h07E0);
    err_exp = 1;
    run("s4", 100);
    chk("s4_strobe_to_error",
        (err_cyc.size() > 0 && strobe_cyc.size() > 0) ? err_cyc[0] - strobe_cyc[0] : -1, 9);
    chk("s4_idle_after_error", dbg_state, IDLE);
    chk("s4_no_grant_while_not_ready", bus.grant, 0);
    // rrPtr advanced past 2: requesters 1 and 3 -> 3 first
    clear_cfg();
    set_wr(1, 0, 8'h12, 9'h034, 16'h5678);
    set_wr(3, 0, 8'h9A, 9'h1BC, 16'hDEF0);
    expect_wr(3, 8'h9A, 9'h1BC, 16'hDEF0);
    expect_wr(1, 8'h12, 9'h034, 16'h5678);
    ack_exp_q.push_back(4'b1000); ack_exp_q.push_back(4'b0010);
    run("s4b", 100);

    // Scenario 5: reset pulsed mid-WAIT
    do_reset();
    rdy_dly = 20;
    set_wr(2, 0, 8'h55, 9'h0AA, 16'h001F);
    expect_wr(2, 8'h55, 9'h0AA, 16'h001F);
    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(negedge clock); driver_step(); t++;
    end
    flag("s5_strobe_missing", exp_q.size() != 0);
    @(negedge clock); driver_step();
    chk("s5_in_wait", dbg_state, WAIT);
    #2 reset = 1'b1;
    #1;
    chk("s5_async_state", dbg_state, IDLE);
    chk("s5_async_grant", bus.grant, 0);
    chk("s5_async_ack", bus.ack, 0);
    chk("s5_async_strobe", bus.lcdPixelWrite, 0);
    chk("s5_async_x", bus.lcdXAddr, 0);
    chk("s5_async_y", bus.lcdYAddr, 0);
    chk("s5_async_pixel", bus.lcdPixelData, 0);
    clear_cfg();
    exp_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    set_wr(3, 0, 8'h99, 9'h199, 16'hFFFF);
    expect_wr(3, 8'h99, 9'h199, 16'hFFFF);
    ack_exp_q.push_back(4'b1000);
    run("s5", 100);

    chk("end_exp_q_empty", exp_q.size(), 0);
    chk("end_ack_q_empty", ack_exp_q.size(), 0);
    chk("end_err_exp_zero", err_exp, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_write_arbiter.md
LCD_WRITE_ARBITER -- requirements
Module: lcd_write_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of pixel-write requesters; legal range 2..8.
REQ-002 Parameter TIMEOUT_CYCLES, default 1000: maximum number of WAIT-state cycles before a write is aborted.
REQ-003 Port clock, input, 1: system clock; all logic is rising-edge triggered.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port req, input, NUM_REQ: per-requester pixel-write request, level, held until ack.
REQ-006 Port lock, input, NUM_REQ: per-requester burst lock; while high, the requester keeps the grant between writes.
REQ-007 Port xAddr, input, NUM_REQ*8: packed x coordinates; requester i occupies bits [8i+7:8i].
REQ-008 Port yAddr, input, NUM_REQ*9: packed y coordinates; requester i occupies bits [9i+8:9i].
REQ-009 Port pixelData, input, NUM_REQ*16: packed RGB565 data; requester i occupies bits [16i+15:16i].
REQ-010 Port ack, output, NUM_REQ: one-cycle pulse to the granted requester when its write completes.
REQ-011 Port error, output, 1: one-cycle pulse when a write times out.
REQ-012 Port grant, output, NUM_REQ: one-hot owner of the LCD port, zero when no requester owns it.
REQ-013 Port lcdXAddr, input/output direction output, 8: registered x coordinate sent to the LCD writer.
REQ-014 Port lcdYAddr, output, 9: registered y coordinate sent to the LCD writer.
REQ-015 Port lcdPixelData, output, 16: registered pixel data sent to the LCD writer.
REQ-016 Port lcdPixelWrite, output, 1: one-cycle write strobe to the LCD writer.
REQ-017 Port lcdPixelReady, input, 1: LCD writer idle and able to accept a write.

Function
REQ-018 The FSM SHALL have four states: IDLE, ISSUE, WAIT and DONE.
REQ-019 In IDLE, when any req bit is high and lcdPixelReady is high, the FSM SHALL select a requester by round robin, starting the search at rrPtr.
REQ-020 On that selection, the block SHALL register the winner's xAddr, yAddr and pixelData, set grant, and move to ISSUE.
REQ-021 In ISSUE, lcdPixelWrite SHALL be high for exactly one cycle; the FSM SHALL then move to WAIT.
REQ-022 WAIT SHALL ignore lcdPixelReady in its first cycle.
REQ-023 From the second WAIT cycle on, lcdPixelReady high SHALL move the FSM to DONE.
REQ-024 In DONE, ack[granted] SHALL pulse for one cycle.
REQ-025 In DONE, if lock and req of the granted requester are both high, the FSM SHALL load that requester's new data, keep grant, and go directly to ISSUE; arbitration is skipped.
REQ-026 Otherwise, DONE SHALL clear grant, set rrPtr to granted index + 1 modulo NUM_REQ, and move to IDLE.
REQ-027 Minimum request-to-strobe latency SHALL be 1 cycle.
REQ-028 Minimum unlocked throughput SHALL be one write per 5 cycles; a locked burst SHALL reach one write per 4 cycles.
REQ-029 A WAIT cycle counter SHALL saturate at TIMEOUT_CYCLES.
REQ-030 On reaching TIMEOUT_CYCLES, the block SHALL pulse error, withhold ack, clear grant, advance rrPtr, and move to IDLE.
REQ-031 A req deassertion by the granted requester after ISSUE SHALL NOT abort the write; its ack still pulses.
REQ-032 Requests that arrive while another requester holds the grant SHALL wait; none are lost while req is held.
REQ-033 lcdPixelReady low in IDLE SHALL hold the FSM in IDLE with no grant.
REQ-034 A lock change SHALL take effect only when sampled in DONE.

Reset
REQ-035 Reset SHALL force state to IDLE and set rrPtr, grant, ack, error, lcdPixelWrite, lcdXAddr, lcdYAddr, lcdPixelData and the timeout counter to 0, regardless of state.
REQ-036 A reset asserted during WAIT SHALL produce no ack.

Structure
REQ-037 The state encodings and the RGB565, x and y width constants SHALL live in a shared package used by all drawing blocks.
REQ-038 The round-robin selection SHALL be a sub-module named rr_priority_select, with inputs req and rrPtr and outputs a one-hot winner and a valid flag.

Verification
REQ-039 Scenario 1: req=0001, x=10, y=20, data=F800, ready returns 3 cycles after the strobe -> one strobe with 10/20/F800, then ack[0] 5 cycles after req.
REQ-040 Scenario 2: req=1111 held, no lock -> grants in the order 0,1,2,3,0, each followed by one ack.
REQ-041 Scenario 3: req=0011, lock[1]=1 with 3 writes -> requester 1 keeps the grant for 3 writes at 4-cycle spacing, then requester 0 is served.
REQ-042 Scenario 4: lcdPixelReady stuck low after the strobe, TIMEOUT_CYCLES=8 -> error pulses after 8 WAIT cycles, no ack, FSM returns to IDLE.
REQ-043 Scenario 5: reset pulsed mid-WAIT -> all outputs go to 0 asynchronously, no ack, and the next request is served normally.
